// File: rtl/arb_defs.sv
// ============================================================================
// Module      : arb_defs (package)
// Description : Shared sizes, state encoding and helpers for the 32-way
//               round-robin arbiter (rr_arbiter32) and its priority encoder.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package arb_defs;

    // Number of requesters. The design only supports 32.
    localparam int N            = 32;
    // Width of the binary grant index (log2 N).
    localparam int IDW          = 5;
    // Default hold-time limit and hold counter width.
    localparam int MAX_HOLD_DEF = 16;
    localparam int CNTW_DEF     = 8;

    // Arbiter FSM states.
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Search start index after a grant ends: one past the previous owner.
    // The 5-bit add wraps 31 back to 0 on its own.
    function automatic logic [IDW-1:0] next_ptr(input logic [IDW-1:0] id);
        return id + 5'd1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter32_lsb_onehot32.sv
// ============================================================================
// Module      : lsb_onehot32
// Description : Combinational 32-bit fixed-priority encoder. The lowest set
//               bit of the input wins.
// Ports       : vec    [31:0] in  - candidate request vector
//               onehot [31:0] out - one-hot winner (zero when vec is zero)
//               idx    [4:0]  out - binary index of winner (zero when none)
//               any           out - high when vec is non-zero
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module lsb_onehot32
    import arb_defs::*;
(
    input  logic [N-1:0]   vec,
    output logic [N-1:0]   onehot,
    output logic [IDW-1:0] idx,
    output logic           any
);

    always_comb begin
        // Two's-complement trick isolates the lowest set bit.
        onehot = vec & (~vec + 32'd1);
        any    = |vec;
        idx    = '0;
        // Scan downwards so the last hit, the lowest index, is kept.
        for (int i = N - 1; i >= 0; i--) begin
            if (vec[i]) begin
                idx = IDW'(i);
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_arbiter32.sv
// ============================================================================
// Module      : rr_arbiter32
// Description : 32-requester round-robin arbiter for one shared datapath.
//               A rotating search pointer masks off requesters below it so
//               the fixed-priority encoder yields fair, starvation-free
//               grants. A grant is held until release, request drop, or the
//               hold-time limit, then one idle turnaround cycle follows.
// Ports       : clk                 in  - rising-edge clock
//               reset               in  - asynchronous active-high reset
//               req         [31:0]  in  - level-sensitive requests
//               release_req         in  - owner finished (used only in BUSY)
//               grant       [31:0]  out - registered one-hot grant
//               grant_valid         out - high while a grant is held
//               grant_id    [4:0]   out - index of holder, 0 when idle
//               timeout             out - one-cycle pulse on forced revoke
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter32
    import arb_defs::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEF,
    parameter int CNTW     = CNTW_DEF
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N-1:0]   req,
    input  logic           release_req,
    output logic [N-1:0]   grant,
    output logic           grant_valid,
    output logic [IDW-1:0] grant_id,
    output logic           timeout
);

    localparam logic [CNTW-1:0] c_hold_last = CNTW'(MAX_HOLD - 1);

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    arb_state_t      state_q,       state_d;
    logic [IDW-1:0]  ptr_q,         ptr_d;
    logic [CNTW-1:0] hold_cnt_q,    hold_cnt_d;
    logic [N-1:0]    grant_q,       grant_d;
    logic            grant_valid_q, grant_valid_d;
    logic [IDW-1:0]  grant_id_q,    grant_id_d;
    logic            timeout_q,     timeout_d;

    // ------------------------------------------------------------------
    // Arbitration datapath
    // ------------------------------------------------------------------
    logic [N-1:0]   w_low_mask;
    logic [N-1:0]   w_hi_mask;
    logic [N-1:0]   w_hi_onehot,  w_all_onehot,  w_win_onehot;
    logic [IDW-1:0] w_hi_idx,     w_all_idx,     w_win_idx;
    logic           w_hi_any,     w_all_any;

    // Requesters at or above ptr have priority; the unmasked path wraps
    // around to the low indices when nothing at or above ptr is asking.
    assign w_low_mask = (32'd1 << ptr_q) - 32'd1;
    assign w_hi_mask  = req & ~w_low_mask;

    lsb_onehot32 u_enc_hi (
        .vec    (w_hi_mask),
        .onehot (w_hi_onehot),
        .idx    (w_hi_idx),
        .any    (w_hi_any)
    );

    lsb_onehot32 u_enc_all (
        .vec    (req),
        .onehot (w_all_onehot),
        .idx    (w_all_idx),
        .any    (w_all_any)
    );

    assign w_win_onehot = w_hi_any ? w_hi_onehot : w_all_onehot;
    assign w_win_idx    = w_hi_any ? w_hi_idx    : w_all_idx;

    // ------------------------------------------------------------------
    // End-of-grant conditions
    // ------------------------------------------------------------------
    logic w_end_rel;
    logic w_end_drop;
    logic w_end_limit;

    assign w_end_rel   = release_req;
    assign w_end_drop  = ~req[grant_id_q];
    assign w_end_limit = (hold_cnt_q == c_hold_last);

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        hold_cnt_d    = hold_cnt_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        timeout_d     = 1'b0;

        if (state_q == IDLE) begin
            if (w_all_any) begin
                grant_d       = w_win_onehot;
                grant_id_d    = w_win_idx;
                grant_valid_d = 1'b1;
                hold_cnt_d    = '0;
                state_d       = BUSY;
            end
        end else begin
            if (w_end_rel || w_end_drop || w_end_limit) begin
                grant_d       = '0;
                grant_id_d    = '0;
                grant_valid_d = 1'b0;
                ptr_d         = next_ptr(grant_id_q);
                state_d       = IDLE;
                // A release or drop on the limit cycle is a normal end.
                timeout_d     = w_end_limit & ~w_end_rel & ~w_end_drop;
            end else begin
                hold_cnt_d    = hold_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            ptr_q         <= '0;
            hold_cnt_q    <= '0;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            timeout_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            ptr_q         <= ptr_d;
            hold_cnt_q    <= hold_cnt_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            timeout_q     <= timeout_d;
        end
    end

    assign grant       = grant_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign timeout     = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_rr_arbiter32.sv
// ============================================================================
// Module      : tb_rr_arbiter32
// Description : Self-checking bench for rr_arbiter32 with a behavioural
//               round-robin reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rr_arbiter32;

    localparam int MAXH = 16;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req;
    logic        rel;
    logic [31:0] grant;
    logic        grant_valid;
    logic [4:0]  grant_id;
    logic        timeout;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state
    bit m_busy;
    int m_ptr;
    int m_id;
    int m_cnt;
    bit m_to;

    always #5 clk = ~clk;

    rr_arbiter32 #(.MAX_HOLD(MAXH), .CNTW(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .release_req (rel),
        .grant       (grant),
        .grant_valid (grant_valid),
        .grant_id    (grant_id),
        .timeout     (timeout)
    );

    // First requester found walking upward from ptr, wrapping at 32.
    function automatic int winner(input logic [31:0] r, input int ptr);
        for (int k = 0; k < 32; k++) begin
            int idx;
            idx = (ptr + k) % 32;
            if (r[idx]) return idx;
        end
        return 0;
    endfunction

    task automatic model_reset();
        m_busy = 0; m_ptr = 0; m_id = 0; m_cnt = 0; m_to = 0;
    endtask

    task automatic model_edge(input logic [31:0] r, input bit rl);
        bit a, b, c;
        if (!m_busy) begin
            m_to = 0;
            if (r != 32'd0) begin
                m_id   = winner(r, m_ptr);
                m_busy = 1;
                m_cnt  = 0;
            end
        end else begin
            a = rl;
            b = !r[m_id];
            c = (m_cnt == MAXH - 1);
            if (a || b || c) begin
                m_busy = 0;
                m_ptr  = (m_id + 1) % 32;
                m_to   = c && !a && !b;
            end else begin
                m_cnt++;
                m_to = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs(input string tag);
        logic [31:0] eg;
        eg = m_busy ? (32'd1 << m_id) : 32'd0;
        check({tag, ".grant"},       grant,              eg);
        check({tag, ".grant_id"},    {27'd0, grant_id},  m_busy ? 32'(m_id) : 32'd0);
        check({tag, ".grant_valid"}, {31'd0, grant_valid}, {31'd0, m_busy});
        check({tag, ".timeout"},     {31'd0, timeout},   {31'd0, m_to});
    endtask

    task automatic step(input logic [31:0] r, input bit rl, input string tag);
        @(negedge clk);
        req = r;
        rel = rl;
        @(posedge clk);
        model_edge(r, rl);
        #1;
        check_outputs(tag);
    endtask

    initial begin
        logic [31:0] r;
        int exp_seq;
        int mode;

        reset = 1'b1;
        req   = '0;
        rel   = 1'b0;
        model_reset();
        #12;
        check_outputs("reset");
        @(negedge clk);
        reset = 1'b0;

        // Single requester, release, then ptr=5 shown by id 5 beating id 4.
        step(32'h0000_0010, 1'b0, "single");
        step(32'h0000_0010, 1'b1, "release");
        step(32'h0000_0000, 1'b0, "idle");
        step(32'h0000_0030, 1'b0, "ptr5");
        step(32'h0000_0000, 1'b0, "drop5");

        // Alternation between ids 0 and 31.
        for (int i = 0; i < 10; i++) begin
            step(32'h8000_0001, m_busy, "alt");
        end
        step(32'h0000_0000, 1'b0, "alt_drain");
        step(32'h0000_0000, 1'b0, "alt_drain2");

        // Fairness / wrap-around: grants ascend from ptr, one per two cycles.
        exp_seq = m_ptr;
        for (int i = 0; i < 80; i++) begin
            step(32'hFFFF_FFFF, m_busy, "fair");
            if (m_busy) begin
                check("fair.order", {27'd0, grant_id}, 32'(exp_seq));
                exp_seq = (exp_seq + 1) % 32;
            end
        end
        step(32'h0000_0000, 1'b0, "fair_drain");
        step(32'h0000_0000, 1'b0, "fair_drain2");

        // Timeout: id 2 held without release.
        for (int i = 0; i < 2 * MAXH + 6; i++) begin
            step(32'h0000_0004, 1'b0, "hold");
        end
        step(32'h0000_0000, 1'b0, "hold_drain");
        step(32'h0000_0000, 1'b0, "hold_drain2");

        // Request drop: id 7 granted, then req[7] removed -> ptr 8.
        step(32'h0000_0080, 1'b0, "g7");
        step(32'h0000_0000, 1'b0, "drop7");
        step(32'h0000_0180, 1'b0, "ptr8");
        step(32'h0000_0000, 1'b0, "drop8");

        // Randomised traffic with sticky request patterns to reach timeouts.
        r = 32'd0;
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 7) == 0) begin
                mode = $urandom_range(0, 3);
                case (mode)
                    0:       r = 32'd0;
                    1:       r = 32'd1 << $urandom_range(0, 31);
                    2:       r = $urandom;
                    default: r = $urandom & $urandom & $urandom;
                endcase
            end
            step(r, ($urandom_range(0, 5) == 0), "rand");
        end
        step(32'h0000_0000, 1'b0, "rand_drain");
        step(32'h0000_0000, 1'b0, "rand_drain2");

        // Asynchronous reset while id 12 holds the grant.
        step(32'h0000_1000, 1'b0, "g12");
        step(32'h0000_1000, 1'b0, "g12_hold");
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check_outputs("async_rst");
        @(negedge clk);
        reset = 1'b0;
        step(32'h1000_1000, 1'b0, "post_rst");
        step(32'h1000_1000, 1'b1, "post_rst_rel");
        step(32'h1000_1000, 1'b0, "post_rst_next");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
